// File: rtl/smash_pkg.sv
// rtl/smash_pkg.sv - attack-word layout, damage defaults and scheduler types shared by the hit path
package smash_pkg;

  localparam int HIT       = 0;
  localparam int SMASH_U   = 1;
  localparam int SMASH_D   = 2;
  localparam int SMASH_L   = 3;
  localparam int SMASH_R   = 4;
  localparam int JAB       = 5;
  localparam int SPECIAL_U = 6;
  localparam int SPECIAL_D = 7;
  localparam int SPECIAL_L = 8;
  localparam int SPECIAL_R = 9;
  localparam int SPECIAL_N = 10;
  localparam int ACTIVE    = 11;

  localparam logic [9:0] DMG_SMASH_DEF   = 10'd12;
  localparam logic [9:0] DMG_SPECIAL_DEF = 10'd8;
  localparam logic [9:0] DMG_JAB_DEF     = 10'd3;
  localparam logic [9:0] DMG_MAX_DEF     = 10'd999;

  typedef enum logic [1:0] {IDLE, APPLY, ISSUE} state_t;

  typedef enum logic [3:0] {
    T_SMASH_U, T_SMASH_D, T_SMASH_L, T_SMASH_R, T_JAB,
    T_SPECIAL_U, T_SPECIAL_D, T_SPECIAL_L, T_SPECIAL_R, T_SPECIAL_N
  } atk_t;

  // Lowest set type bit wins; a hit with no type bit counts as a jab.
  function automatic atk_t decode_type(input logic [9:0] kind);
    atk_t t;
    casez (kind)
      10'b?????????1: t = T_SMASH_U;
      10'b????????10: t = T_SMASH_D;
      10'b???????100: t = T_SMASH_L;
      10'b??????1000: t = T_SMASH_R;
      10'b?????10000: t = T_JAB;
      10'b????100000: t = T_SPECIAL_U;
      10'b???1000000: t = T_SPECIAL_D;
      10'b??10000000: t = T_SPECIAL_L;
      10'b?100000000: t = T_SPECIAL_R;
      10'b1000000000: t = T_SPECIAL_N;
      default:        t = T_JAB;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/knockback_calc.sv
// rtl/knockback_calc.sv - combinational knockback vector from attack type, post-hit damage and positions
module knockback_calc
  import smash_pkg::*;
#(
  parameter logic [15:0] KB_BASE = 16'h0200
) (
  input  logic [3:0]  atk_type,
  input  logic [9:0]  damage,
  input  logic [15:0] atk_x,
  input  logic [15:0] vic_x,
  output logic [31:0] vector
);

  logic [16:0] mag_raw;
  logic [15:0] mag, mag_neg, lift, side, dx, dy;

  assign mag_raw = {1'b0, KB_BASE} + {5'b0, damage, 2'b00};
  assign mag     = (mag_raw > 17'h07FFF) ? 16'h7FFF : mag_raw[15:0];
  assign mag_neg = -mag;
  assign lift    = {3'b000, mag[15:3]};
  // Horizontal-only hits push the victim away from the attacker.
  assign side    = (vic_x >= atk_x) ? {2'b00, mag[15:2]} : -{2'b00, mag[15:2]};

  always_comb begin
    dx = '0;
    dy = '0;
    case (atk_t'(atk_type))
      T_SMASH_U, T_SPECIAL_U: dy = mag;
      T_SMASH_D, T_SPECIAL_D: dy = mag_neg;
      T_SMASH_L, T_SPECIAL_L: begin dx = mag_neg; dy = lift; end
      T_SMASH_R, T_SPECIAL_R: begin dx = mag;     dy = lift; end
      default:                dx = side;
    endcase
  end

  assign vector = {dx, dy};

endmodule

// File: rtl/hit_scheduler.sv
// rtl/hit_scheduler.sv - serialises both players' hits into knockback requests; owns damage and hitstun
module hit_scheduler
  import smash_pkg::*;
#(
  parameter logic [9:0]  DMG_SMASH   = DMG_SMASH_DEF,
  parameter logic [9:0]  DMG_SPECIAL = DMG_SPECIAL_DEF,
  parameter logic [9:0]  DMG_JAB     = DMG_JAB_DEF,
  parameter logic [9:0]  DMG_MAX     = DMG_MAX_DEF,
  parameter logic [15:0] KB_BASE     = 16'h0200,
  parameter logic [23:0] HITSTUN     = 24'h400000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] attack1,
  input  logic [31:0] attack2,
  input  logic [15:0] char1x,
  input  logic [15:0] char2x,
  input  logic        clear_damage,
  input  logic        kb_ready,
  output logic        kb_valid,
  output logic        kb_target,
  output logic [31:0] kb_vector,
  output logic [9:0]  damage1,
  output logic [9:0]  damage2,
  output logic        hitstun1,
  output logic        hitstun2
);

  state_t state, state_nxt;
  logic gnt, gnt_nxt, ptr, ptr_nxt, victim;
  logic [1:0] pending, stunned;
  logic [1:0][31:0] atk;
  logic [1:0][15:0] xpos;
  logic [1:0][3:0]  ptype;
  logic [1:0][9:0]  dmg;
  logic [9:0]  dmg_add, dmg_post;
  logic [10:0] dmg_sum;
  logic [31:0] vec_calc;
  logic unused_bits;

  assign atk         = {attack2, attack1};
  assign xpos        = {char2x, char1x};
  assign unused_bits = ^{attack1[31:12], attack2[31:12]};
  assign victim      = ~gnt;
  assign kb_valid    = (state == ISSUE);
  assign damage1     = dmg[0];
  assign damage2     = dmg[1];
  assign hitstun1    = stunned[0];
  assign hitstun2    = stunned[1];

  // Index 0 is player 1; each player's victim is the other index.
  for (genvar g = 0; g < 2; g++) begin : g_player
    logic        pend_q, scored_q;
    logic [3:0]  type_q;
    logic [9:0]  dmg_q;
    logic [23:0] stun_q;

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        pend_q   <= 1'b0;
        scored_q <= 1'b0;
        type_q   <= '0;
        dmg_q    <= '0;
        stun_q   <= '0;
      end else begin
        if (state == APPLY && gnt == 1'(g)) pend_q <= 1'b0;
        if (!atk[g][ACTIVE]) scored_q <= 1'b0;
        else if (atk[g][HIT] && !scored_q) begin
          scored_q <= 1'b1;
          if (!stunned[1-g]) begin
            pend_q <= 1'b1;
            type_q <= decode_type(atk[g][SPECIAL_N:SMASH_U]);
          end
        end
        if (clear_damage) dmg_q <= '0;
        else if (state == APPLY && victim == 1'(g)) dmg_q <= dmg_post;
        if (kb_valid && kb_ready && kb_target == 1'(g)) stun_q <= HITSTUN;
        else if (stun_q != '0) stun_q <= stun_q - 24'd1;
      end
    end

    assign pending[g] = pend_q;
    assign ptype[g]   = type_q;
    assign dmg[g]     = dmg_q;
    assign stunned[g] = (stun_q != '0);
  end

  always_comb begin
    dmg_add = DMG_SPECIAL;
    case (atk_t'(ptype[gnt]))
      T_SMASH_U, T_SMASH_D, T_SMASH_L, T_SMASH_R: dmg_add = DMG_SMASH;
      T_JAB:                                      dmg_add = DMG_JAB;
      default:                                    dmg_add = DMG_SPECIAL;
    endcase
  end

  assign dmg_sum  = {1'b0, dmg[victim]} + {1'b0, dmg_add};
  assign dmg_post = (dmg_sum > {1'b0, DMG_MAX}) ? DMG_MAX : dmg_sum[9:0];

  knockback_calc #(.KB_BASE(KB_BASE)) u_knockback (
    .atk_type (ptype[gnt]),
    .damage   (dmg_post),
    .atk_x    (xpos[gnt]),
    .vic_x    (xpos[victim]),
    .vector   (vec_calc)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      gnt       <= 1'b0;
      ptr       <= 1'b0;
      kb_target <= 1'b0;
      kb_vector <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      ptr   <= ptr_nxt;
      if (state == APPLY) begin
        kb_target <= victim;
        kb_vector <= vec_calc;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    ptr_nxt   = ptr;
    case (state)
      IDLE: if (|pending) begin
        gnt_nxt   = (&pending) ? ptr : pending[1];
        ptr_nxt   = ~gnt_nxt;
        state_nxt = APPLY;
      end
      APPLY:   state_nxt = ISSUE;
      ISSUE:   if (kb_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_hit_scheduler.sv
// tb/tb_hit_scheduler.sv - scoreboard bench for hit_scheduler with directed hit sequences
module tb_hit_scheduler;

  localparam int STUN = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] attack1 = '0, attack2 = '0;
  logic [15:0] char1x = 16'd100, char2x = 16'd200;
  logic        clear_damage = 1'b0, kb_ready = 1'b0;
  logic        kb_valid, kb_target, hitstun1, hitstun2;
  logic [31:0] kb_vector;
  logic [9:0]  damage1, damage2;

  typedef struct packed { logic target; logic [31:0] vector; } exp_t;
  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int d2;

  hit_scheduler #(.HITSTUN(24'(STUN))) dut (
    .clock(clock), .reset(reset), .attack1(attack1), .attack2(attack2),
    .char1x(char1x), .char2x(char2x), .clear_damage(clear_damage), .kb_ready(kb_ready),
    .kb_valid(kb_valid), .kb_target(kb_target), .kb_vector(kb_vector),
    .damage1(damage1), .damage2(damage2), .hitstun1(hitstun1), .hitstun2(hitstun2)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (reset && kb_valid && kb_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_request: got target %0d vector %h want none", kb_target, kb_vector);
      end else begin
        e = exp_q.pop_front();
        check("kb_target", 32'(kb_target), 32'(e.target));
        check("kb_vector", kb_vector, e.vector);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic wait_valid(input string name);
    int k = 0;
    while (!kb_valid && k < 50) begin
      tick(1);
      k++;
    end
    if (!kb_valid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: kb_valid got 0 want 1 within 50 cycles", name);
    end
  endtask

  task automatic do_hit(input int pl, input logic [31:0] word, input logic tgt, input logic [31:0] vec);
    exp_q.push_back({tgt, vec});
    if (pl == 1) attack1 = word; else attack2 = word;
    tick(1);
    wait_valid("single_hit");
    tick(2);
    if (pl == 1) attack1 = '0; else attack2 = '0;
    tick(STUN + 4);
  endtask

  task automatic do_pair(input logic [31:0] w1, input logic [31:0] w2,
                         input logic t0, input logic [31:0] v0, input logic t1, input logic [31:0] v1);
    exp_q.push_back({t0, v0});
    exp_q.push_back({t1, v1});
    attack1 = w1;
    attack2 = w2;
    tick(1);
    wait_valid("pair_hit");
    tick(6);
    attack1 = '0;
    attack2 = '0;
    tick(STUN + 4);
  endtask

  function automatic logic [15:0] mag(input int d);
    int m = 512 + 4 * d;
    return (m > 32'h7FFF) ? 16'h7FFF : 16'(m);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tick(2);
    check("rst_kb_valid", 32'(kb_valid), 32'h0);
    check("rst_kb_target", 32'(kb_target), 32'h0);
    check("rst_kb_vector", kb_vector, 32'h0);
    check("rst_damage", {12'h0, damage1, damage2}, 32'h0);
    check("rst_hitstun", {30'h0, hitstun1, hitstun2}, 32'h0);
    reset = 1'b1;
    kb_ready = 1'b1;
    tick(2);

    exp_q.push_back({1'b1, 32'h0000_0230});
    attack1 = 32'h803;
    tick(2);
    check("latency_apply_valid", 32'(kb_valid), 32'h0);
    check("latency_apply_damage2", 32'(damage2), 32'd0);
    tick(1);
    check("latency_issue_valid", 32'(kb_valid), 32'h1);
    check("smash_damage2", 32'(damage2), 32'd12);
    tick(1);
    check("smash_hitstun2", 32'(hitstun2), 32'h1);
    tick(100);
    check("window_damage2", 32'(damage2), 32'd12);
    attack1 = '0;
    tick(STUN + 4);
    check("hitstun2_expired", 32'(hitstun2), 32'h0);

    do_hit(2, 32'h811, 1'b0, 32'h0230_0046);
    check("right_smash_damage1", 32'(damage1), 32'd12);

    do_pair(32'h821, 32'h821, 1'b1, 32'h008F_0000, 1'b0, 32'hFF71_0000);
    check("pair1_damage", {12'h0, damage1, damage2}, {12'h0, 10'd15, 10'd15});
    do_hit(1, 32'h805, 1'b1, 32'h0000_FD94);
    do_pair(32'h901, 32'hC01, 1'b0, 32'hFF69_0000, 1'b1, 32'hFD74_0051);
    check("pair2_damage", {12'h0, damage1, damage2}, {12'h0, 10'd23, 10'd35});

    kb_ready = 1'b0;
    exp_q.push_back({1'b1, 32'h02BC_0057});
    attack1 = 32'h811;
    tick(1);
    wait_valid("backpressure");
    for (int i = 0; i < 20; i++) begin
      check("bp_valid", 32'(kb_valid), 32'h1);
      check("bp_vector", kb_vector, 32'h02BC_0057);
      check("bp_hitstun2", 32'(hitstun2), 32'h0);
      tick(1);
    end
    kb_ready = 1'b1;
    tick(1);
    check("bp_done_valid", 32'(kb_valid), 32'h0);
    check("bp_done_hitstun2", 32'(hitstun2), 32'h1);

    attack1 = '0;
    tick(1);
    attack1 = 32'h803;
    tick(4);
    check("discard_hitstun2", 32'(hitstun2), 32'h1);
    tick(30);
    check("discard_damage2", 32'(damage2), 32'd47);
    check("discard_valid", 32'(kb_valid), 32'h0);
    attack1 = '0;
    tick(2);

    kb_ready = 1'b0;
    exp_q.push_back({1'b0, 32'hFF66_0000});
    attack2 = 32'h821;
    tick(1);
    wait_valid("clear_issue");
    check("clear_pre_damage1", 32'(damage1), 32'd26);
    clear_damage = 1'b1;
    tick(1);
    clear_damage = 1'b0;
    check("clear_damage", {12'h0, damage1, damage2}, 32'h0);
    check("clear_still_valid", 32'(kb_valid), 32'h1);
    kb_ready = 1'b1;
    tick(1);
    check("clear_done_valid", 32'(kb_valid), 32'h0);
    attack2 = '0;
    tick(STUN + 4);

    d2 = 0;
    for (int i = 0; i < 82; i++) begin
      d2 = d2 + 12;
      do_hit(1, 32'h813, 1'b1, {16'h0, mag(d2)});
    end
    check("preload_984", 32'(damage2), 32'd984);
    do_hit(1, 32'h841, 1'b1, 32'h0000_1180);
    do_hit(1, 32'h801, 1'b1, 32'h0463_0000);
    check("preload_995", 32'(damage2), 32'd995);
    do_hit(1, 32'h803, 1'b1, 32'h0000_119C);
    check("sat_999", 32'(damage2), 32'd999);
    do_hit(1, 32'h803, 1'b1, 32'h0000_119C);
    check("sat_hold_999", 32'(damage2), 32'd999);

    kb_ready = 1'b0;
    attack1 = 32'h803;
    tick(1);
    wait_valid("reset_issue");
    #1 reset = 1'b0;
    #1;
    check("async_rst_valid", 32'(kb_valid), 32'h0);
    check("async_rst_vector", kb_vector, 32'h0);
    check("async_rst_damage2", 32'(damage2), 32'd0);
    attack1 = '0;
    tick(2);
    reset = 1'b1;
    kb_ready = 1'b1;
    tick(4);
    check("post_rst_valid", 32'(kb_valid), 32'h0);
    check("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hit_scheduler.md
# hit_scheduler

Serialises hit events from the two per-player attack coprocessors into one stream of knockback requests for the physics engine, and owns each character's damage percentage and hitstun. It sits between the two attack coprocessor `attack` outputs and the physics engine's knockback input. It scores each attack window at most once and arbitrates round-robin when both players land hits in the same cycle. It scales knockback by the victim's post-hit damage.

## Interface
Parameters:
- `DMG_SMASH`, 12: percent added by a smash hit.
- `DMG_SPECIAL`, 8: percent added by any B-button hit.
- `DMG_JAB`, 3: percent added by a jab.
- `DMG_MAX`, 999: damage saturation value.
- `KB_BASE`, 16'h0200: base knockback magnitude.
- `HITSTUN`, 24'h400000: hitstun length in cycles.

Ports:
- `clock`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-low reset.
- `attack1`, in, 32: player-1 coprocessor attack word. Bit 0 = hit, bits 1-10 = type (up/down/left/right smash, jab, up/down/left/right/neutral special), bit 11 = attack active.
- `attack2`, in, 32: same format, player 2.
- `char1x`, in, 16: player-1 X position, unsigned.
- `char2x`, in, 16: player-2 X position, unsigned.
- `clear_damage`, in, 1: zero both damage counters (new stock or round).
- `kb_ready`, in, 1: physics accepts the knockback request.
- `kb_valid`, out, 1: knockback request valid.
- `kb_target`, out, 1: victim select; 0 = char1, 1 = char2.
- `kb_vector`, out, 32: `{dx[15:0], dy[15:0]}`, two's complement.
- `damage1`, out, 10: player-1 damage percent.
- `damage2`, out, 10: player-2 damage percent.
- `hitstun1`, out, 1: player 1 is in hitstun.
- `hitstun2`, out, 1: player 2 is in hitstun.

## Operation
- **Per-player window tracking.** Each attacker has a `scored` flag, set when its hit is latched and cleared on the cycle `attack[11]` is sampled low.
- **Pending latch.** `pending` is set when `attack[0] & attack[11] & ~scored`.
- **Hits on a victim in hitstun** are discarded: `scored` is set and `pending` is not set.
- **States:** IDLE, APPLY, ISSUE.
- **IDLE.** If any `pending` is set, grant one attacker and go to APPLY. When both are pending, the round-robin pointer chooses; the pointer moves to the other player after every grant.
- **APPLY** (one cycle):
  - Clear the winner's `pending`.
  - Add the damage for the attack type to the victim's damage, saturating at `DMG_MAX`.
  - Register `kb_vector` and `kb_target`.
  - Go to ISSUE.
- **ISSUE.** Hold `kb_valid` high with `kb_vector`/`kb_target` stable until `kb_ready`. On the accepting cycle:
  - Load the victim's hitstun counter with `HITSTUN`.
  - Return to IDLE.
- **Attack type** is taken from the lowest set bit in 1-10. If none of bits 1-10 is set, the hit is treated as a jab.
- **Knockback magnitude:** M = `KB_BASE` + (post-hit damage << 2), computed in 17 bits and saturated to 16'h7FFF.
- **Knockback direction:**
  - Up: (0, +M).
  - Down: (0, -M).
  - Left: (-M, M>>3).
  - Right: (+M, M>>3).
  - Jab and neutral special: horizontal only, magnitude M>>2. The sign is away from the attacker: + if victim X ≥ attacker X, else -. dy = 0.
- **Hitstun counters** decrement to 0. `hitstunN` = (counter ≠ 0).
- **`clear_damage`** zeroes both damages and takes priority over an APPLY update in the same cycle. Any request in ISSUE still completes unchanged.

## Timing
- **Reset** (`reset` low): state = IDLE, `pending` = 0, `scored` = 0, pointer = player 1, `kb_valid` = 0, `kb_target` = 0, `kb_vector` = 0, `damage1`/`damage2` = 0, hitstun counters = 0.
- **Reset mid-ISSUE** drops the request immediately.
- **Latency:**
  - Hit sampled at edge N sets `pending`.
  - APPLY occurs in cycle N+1.
  - `kb_valid` is high from edge N+2.
  - Damage is visible at edge N+2.
- **Back-to-back throughput:** one request per 3 cycles (IDLE, APPLY, ISSUE) when `kb_ready` is held high.
- **Simultaneous hits:** both are latched. The second is serviced immediately after the first returns to IDLE.
- **Stun-check order:** a hit arriving while its victim's request is in APPLY/ISSUE is still latched. The hitstun check applies only at latch time.

## Structure
- Shared package `smash_pkg` holds:
  - attack-word bit indices (HIT=0, SMASH_U..SPECIAL_N=1..10, ACTIVE=11);
  - damage defaults;
  - the state enum {IDLE, APPLY, ISSUE}.
- Sub-module `knockback_calc` is purely combinational: (type, post-hit damage, attacker X, victim X) -> `kb_vector`.

## Test plan
- **Single smash.** `attack1` = 0x803 (up smash hit), `kb_ready` = 1 -> `kb_valid` at edge +2, `kb_target` = 1, `damage2` = 12, `kb_vector` = 0x00000230. Window held 100 cycles -> no second request.
- **Simultaneous hits.** Jab from each side in the same cycle, pointer at player 1 -> first request `kb_target` = 1, second `kb_target` = 0. Next simultaneous pair -> `kb_target` = 0 first.
- **Backpressure.** `kb_ready` low for 20 cycles -> `kb_valid`/`kb_vector` stable throughout; hitstun2 rises only after the accept edge.
- **Saturation.** Preload `damage2` = 995 via repeated hits, then a smash -> `damage2` = 999. M saturates at 16'h7FFF when applicable.
- **Hitstun discard.** Second player-1 hit during player-2 hitstun -> no request, no damage change.
- **Reset.** `clear_damage` during ISSUE -> damages 0, request completes. Asynchronous reset mid-ISSUE -> `kb_valid` = 0 immediately.
